// File: rtl/eth_tx_frame.sv
// rtl/eth_tx_frame.sv - 10BASE-T Manchester frame transmitter with NLP link pulses
// Defining ETH_TX_PAD_EN enables zero padding of short payloads up to MIN_LEN.
module eth_tx_frame #(
  parameter int ADDR_W         = 10,
  parameter int PREAMBLE_BYTES = 7,
  parameter int LINK_PERIOD    = 320000,
  parameter int TP_IDLE_TICKS  = 6,
  parameter int IPG_TICKS      = 193,
  parameter int MIN_LEN        = 60
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_en,
  input  logic              start,
  input  logic [ADDR_W:0]   frame_len,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              tx_p,
  output logic              tx_n,
  output logic              tx_busy,
  output logic              done,
  output logic              bram_rd_en,
  output logic [ADDR_W-1:0] bram_rd_addr,
  input  logic [7:0]        bram_rd_data
);

  localparam int LEN_W   = ADDR_W + 1;
  localparam int LT_W    = (LINK_PERIOD > 1) ? $clog2(LINK_PERIOD) : 1;
  localparam int GAP_MAX = (IPG_TICKS > TP_IDLE_TICKS) ? IPG_TICKS : TP_IDLE_TICKS;
  localparam int GAP_W   = $clog2(GAP_MAX + 1);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1 << ADDR_W);

`ifdef ETH_TX_PAD_EN
  typedef enum logic [2:0] {
    S_LINK, S_PREAMBLE, S_SFD, S_DATA, S_PAD, S_FCS, S_TP_IDLE, S_IPG
  } state_t;
`else
  typedef enum logic [2:0] {
    S_LINK, S_PREAMBLE, S_SFD, S_DATA, S_FCS, S_TP_IDLE, S_IPG
  } state_t;
`endif

  state_t             state, state_n;
  logic [3:0]         tick_cnt;
  logic [LEN_W-1:0]   byte_idx, idx_inc, len;
  logic [7:0]         cur_byte, nxt_byte, fetched;
  logic               rd_q, rd_go, byte_end, len_ok;
  logic [31:0]        crc;
  logic [LT_W-1:0]    link_timer;
  logic [GAP_W-1:0]   gap_cnt;
  logic               cur_bit, half_val, line_p, line_n;

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic b);
    crc_step = {c[30:0], 1'b0} ^ ((c[31] ^ b) ? 32'h04C1_1DB7 : 32'h0);
  endfunction

  assign idx_inc  = byte_idx + LEN_W'(1);
  assign byte_end = clk_en && (tick_cnt == 4'd15);
  // Read data may arrive on the very clock of the byte boundary when clk_en is continuous.
  assign fetched  = rd_q ? bram_rd_data : nxt_byte;
  assign tx_busy  = (state != S_LINK);
  assign rd_go    = (tick_cnt == 4'd13) &&
                    (((state == S_SFD) && (len != '0)) || ((state == S_DATA) && (idx_inc < len)));

`ifdef ETH_TX_PAD_EN
  assign len_ok = 1'b1;
`else
  assign len_ok = (frame_len != '0);
`endif

  always_comb begin
    state_n = state;
    case (state)
      S_LINK:     if (clk_en && start && len_ok) state_n = S_PREAMBLE;
      S_PREAMBLE: if (byte_end && (byte_idx == LEN_W'(PREAMBLE_BYTES - 1))) state_n = S_SFD;
      S_SFD: if (byte_end) begin
`ifdef ETH_TX_PAD_EN
        state_n = (len != '0) ? S_DATA : S_PAD;
`else
        state_n = S_DATA;
`endif
      end
      S_DATA: if (byte_end && (idx_inc >= len)) begin
`ifdef ETH_TX_PAD_EN
        state_n = (idx_inc < LEN_W'(MIN_LEN)) ? S_PAD : S_FCS;
`else
        state_n = S_FCS;
`endif
      end
`ifdef ETH_TX_PAD_EN
      S_PAD:      if (byte_end && (idx_inc >= LEN_W'(MIN_LEN))) state_n = S_FCS;
`endif
      S_FCS:      if (byte_end && (byte_idx == LEN_W'(3))) state_n = S_TP_IDLE;
      S_TP_IDLE:  if (clk_en && (gap_cnt == GAP_W'(TP_IDLE_TICKS - 1))) state_n = S_IPG;
      S_IPG:      if (clk_en && (gap_cnt == GAP_W'(IPG_TICKS - 1))) state_n = S_LINK;
      default:    state_n = S_LINK;
    endcase
  end

  // Line value for the half-bit described by the current state; it reaches tx_p one tick later.
  always_comb begin
    cur_bit = cur_byte[tick_cnt[3:1]];
    if (state == S_FCS) cur_bit = ~crc[31];
    half_val = tick_cnt[0] ? cur_bit : ~cur_bit;
    line_p   = half_val;
    case (state)
      S_LINK:    line_p = (link_timer == '0);
      S_TP_IDLE: line_p = 1'b1;
      S_IPG:     line_p = 1'b0;
      default:   line_p = half_val;
    endcase
    line_n = ((state == S_LINK) || (state == S_IPG)) ? 1'b0 : ~line_p;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_LINK;
    else        state <= state_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_p         <= 1'b0;
      tx_n         <= 1'b0;
      done         <= 1'b0;
      bram_rd_en   <= 1'b0;
      bram_rd_addr <= '0;
      rd_q         <= 1'b0;
      nxt_byte     <= '0;
      cur_byte     <= '0;
      len          <= '0;
      byte_idx     <= '0;
      tick_cnt     <= '0;
      gap_cnt      <= '0;
      crc          <= '0;
      link_timer   <= '0;
    end else begin
      done       <= 1'b0;
      bram_rd_en <= 1'b0;
      rd_q       <= bram_rd_en;
      if (bram_rd_en) bram_rd_addr <= bram_rd_addr + ADDR_W'(1);
      if (rd_q) nxt_byte <= bram_rd_data;
      if (clk_en) begin
        link_timer <= (link_timer == LT_W'(LINK_PERIOD - 1)) ? '0 : link_timer + LT_W'(1);
        tx_p       <= line_p;
        tx_n       <= line_n;
        if (rd_go) bram_rd_en <= 1'b1;
        if ((state == S_LINK) || (state == S_TP_IDLE) || (state == S_IPG)) tick_cnt <= '0;
        else tick_cnt <= tick_cnt + 4'd1;
        case (state)
          S_LINK: if (state_n == S_PREAMBLE) begin
            len          <= (frame_len > MAX_LEN) ? MAX_LEN : frame_len;
            bram_rd_addr <= base_addr;
            crc          <= 32'hFFFF_FFFF;
            byte_idx     <= '0;
            cur_byte     <= 8'h55;
            gap_cnt      <= '0;
          end
          S_PREAMBLE: if (byte_end) begin
            if (state_n == S_SFD) begin
              byte_idx <= '0;
              cur_byte <= 8'hD5;
            end else begin
              byte_idx <= idx_inc;
            end
          end
          S_SFD: if (byte_end) begin
            byte_idx <= '0;
            cur_byte <= (state_n == S_DATA) ? fetched : 8'h00;
          end
          S_DATA: begin
            if (tick_cnt[0]) crc <= crc_step(crc, cur_bit);
            if (byte_end) begin
              byte_idx <= (state_n == S_FCS) ? '0 : idx_inc;
              cur_byte <= (state_n == S_DATA) ? fetched : 8'h00;
            end
          end
`ifdef ETH_TX_PAD_EN
          S_PAD: begin
            if (tick_cnt[0]) crc <= crc_step(crc, cur_bit);
            if (byte_end) byte_idx <= (state_n == S_FCS) ? '0 : idx_inc;
          end
`endif
          S_FCS: begin
            if (tick_cnt[0]) crc <= {crc[30:0], 1'b0};
            if (byte_end) byte_idx <= idx_inc;
          end
          S_TP_IDLE: gap_cnt <= (state_n == S_IPG) ? '0 : gap_cnt + GAP_W'(1);
          S_IPG: begin
            if (state_n == S_LINK) begin
              gap_cnt <= '0;
              done    <= 1'b1;
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
